// File: rtl/mindy_pkg.sv
// Shared definitions for the mindy stream blocks: FSM state type, beat-size
// derivation and constants shared with the mindy interface.
package mindy_pkg;

   localparam int DATA_WBITS_DEFAULT = 512;
   localparam int METADATA_BYTES     = 128;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fd_state_t;

   // Byte counts become beat counts by shifting right by log2(bytes per beat).
   function automatic int bpb_log2(input int data_wbits);
      return $clog2(data_wbits / 8);
   endfunction

endpackage

// File: rtl/mindy_axis_skid.sv
// Two-entry AXI-stream register slice. The head entry drives the output
// directly, so the payload stays stable while the consumer stalls.
module mindy_axis_skid #(
   parameter int WIDTH = 514
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             has_room_next,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   logic [1:0]       count;
   logic [1:0]       count_next;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             push;
   logic             pop;

   // has_room_next lets the owner register its ready one cycle ahead.
   always_comb begin
      pop           = (count != 2'd0) && out_ready;
      push          = in_valid && ((count != 2'd2) || pop);
      count_next    = count + {1'b0, push} - {1'b0, pop};
      has_room_next = (count_next != 2'd2);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= in_data;
               else               tail <= in_data;
            end
            2'b01: head <= tail;
            2'b11: begin
               if (count == 2'd1) begin
                  head <= in_data;
               end else begin
                  head <= tail;
                  tail <= in_data;
               end
            end
            default: ;
         endcase
         count <= count_next;
      end
   end

   assign out_valid = (count != 2'd0);
   assign out_data  = head;

endmodule

// File: rtl/mindy_fd_packetizer.sv
// Slices the raw frame-data beat stream into packets, adding TLAST at packet
// and frame ends and TUSER on the first beat of every frame.
module mindy_fd_packetizer
   import mindy_pkg::*;
#(
   parameter int DATA_WBITS = DATA_WBITS_DEFAULT,
   parameter int CNT_WBITS  = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WBITS-1:0] AXIS_FD_TDATA,
   input  logic                  AXIS_FD_TVALID,
   output logic                  AXIS_FD_TREADY,
   output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
   output logic                  AXIS_OUT_TVALID,
   output logic                  AXIS_OUT_TLAST,
   output logic                  AXIS_OUT_TUSER,
   input  logic                  AXIS_OUT_TREADY,
   input  logic [31:0]           FRAME_SIZE,
   input  logic [31:0]           PACKET_SIZE,
   output logic [CNT_WBITS-1:0]  FRAME_COUNT,
   output logic                  CFG_ERR
);

   localparam int BPB_LOG2 = bpb_log2(DATA_WBITS);
   localparam int PW       = DATA_WBITS + 2;
   localparam logic [CNT_WBITS-1:0] ONE = {{(CNT_WBITS-1){1'b0}}, 1'b1};

   fd_state_t            state;
   fd_state_t            state_next;
   logic [31:0]          frame_beats_in;
   logic [31:0]          pkt_beats_in;
   logic                 cfg_ok;
   logic [CNT_WBITS-1:0] frame_beats;
   logic [CNT_WBITS-1:0] pkt_beats;
   logic [CNT_WBITS-1:0] beat_in_frame;
   logic [CNT_WBITS-1:0] beat_in_pkt;
   logic [CNT_WBITS-1:0] frame_count;
   logic                 tready_q;
   logic                 tready_d;
   logic                 cfg_err_q;
   logic                 cfg_err_d;
   logic                 accept;
   logic                 beat_first;
   logic                 beat_last;
   logic                 frame_end;
   logic                 room_next;
   logic [PW-1:0]        out_payload;

   always_comb begin
      frame_beats_in = FRAME_SIZE >> BPB_LOG2;
      pkt_beats_in   = PACKET_SIZE >> BPB_LOG2;
      cfg_ok         = (frame_beats_in != 32'd0) && (pkt_beats_in != 32'd0) &&
                       (pkt_beats_in <= frame_beats_in);
      accept         = AXIS_FD_TVALID && tready_q;
      beat_first     = (beat_in_frame == ONE);
      frame_end      = (beat_in_frame == frame_beats);
      beat_last      = (beat_in_pkt == pkt_beats) || frame_end;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // Every frame ends with a single IDLE cycle so new sizes are picked up.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cfg_ok) state_next = RUN;
         RUN:     if (accept && frame_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tready_d  = (state_next == RUN) && room_next;
      cfg_err_d = (state == IDLE) ? !cfg_ok : cfg_err_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tready_q  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         tready_q  <= tready_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Sizes are sampled only while idle, so mid-frame changes wait for the boundary.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_beats   <= '0;
         pkt_beats     <= '0;
         beat_in_frame <= ONE;
         beat_in_pkt   <= ONE;
         frame_count   <= '0;
      end else begin
         if (state == IDLE) begin
            frame_beats <= CNT_WBITS'(frame_beats_in);
            pkt_beats   <= CNT_WBITS'(pkt_beats_in);
         end
         if (accept) begin
            if (frame_end) begin
               beat_in_frame <= ONE;
               beat_in_pkt   <= ONE;
               frame_count   <= frame_count + ONE;
            end else begin
               beat_in_frame <= beat_in_frame + ONE;
               beat_in_pkt   <= beat_last ? ONE : (beat_in_pkt + ONE);
            end
         end
      end
   end

   mindy_axis_skid #(
      .WIDTH (PW)
   ) u_skid (
      .clk           (clk),
      .resetn        (resetn),
      .in_valid      (accept),
      .in_data       ({beat_first, beat_last, AXIS_FD_TDATA}),
      .has_room_next (room_next),
      .out_valid     (AXIS_OUT_TVALID),
      .out_data      (out_payload),
      .out_ready     (AXIS_OUT_TREADY)
   );

   assign {AXIS_OUT_TUSER, AXIS_OUT_TLAST, AXIS_OUT_TDATA} = out_payload;
   assign AXIS_FD_TREADY = tready_q;
   assign FRAME_COUNT    = frame_count;
   assign CFG_ERR        = cfg_err_q;

endmodule
